// File: rtl/relprime_pkg.sv
// ============================================================================
// Module   : relprime_pkg
// Purpose  : Shared types and constants for the relprime checker and its
//            binary-GCD engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package relprime_pkg;

    // Default datapath width for n, m and the gcd result
    localparam int c_WIDTH = 16;

    typedef logic [c_WIDTH-1:0] word_t;

    // Top-level checker sequencing
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK_M = 2'd1,
        SWEEP   = 2'd2,
        FINISH  = 2'd3
    } chk_state_t;

    // GCD engine sequencing
    typedef enum logic [1:0] {
        E_IDLE = 2'd0,
        E_RUN  = 2'd1,
        E_DONE = 2'd2
    } eng_state_t;

endpackage

`default_nettype wire

// File: rtl/relprime_checker_gcd_engine.sv
// ============================================================================
// Module   : gcd_engine
// Purpose  : Iterative binary (Stein) GCD, one reduction step per clock.
//            A go pulse loads the operands; done pulses for one cycle with
//            the result the cycle after the terminating condition is seen.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gcd_engine
    import relprime_pkg::*;
#(
    parameter int WIDTH = c_WIDTH
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    // Shift counter must reach WIDTH-1 common factors of two
    localparam int c_SW = $clog2(WIDTH) + 1;

    eng_state_t        r_state;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [c_SW-1:0]   r_s;
    logic              r_done;
    logic [WIDTH-1:0]  r_result;

    // One binary-GCD step per cycle; a new go is accepted whenever not running
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state  <= E_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_s      <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                E_RUN: begin
                    if (r_a == '0) begin
                        r_result <= r_b << r_s;
                        r_done   <= 1'b1;
                        r_state  <= E_DONE;
                    end else if (r_b == '0) begin
                        r_result <= r_a << r_s;
                        r_done   <= 1'b1;
                        r_state  <= E_DONE;
                    end else if (!r_a[0] && !r_b[0]) begin
                        r_a <= r_a >> 1;
                        r_b <= r_b >> 1;
                        r_s <= r_s + 1'b1;
                    end else if (!r_a[0]) begin
                        r_a <= r_a >> 1;
                    end else if (!r_b[0]) begin
                        r_b <= r_b >> 1;
                    end else if (r_a >= r_b) begin
                        r_a <= r_a - r_b;
                    end else begin
                        r_b <= r_b - r_a;
                    end
                end
                default: begin
                    // E_IDLE and E_DONE both accept a launch so that the
                    // checker can relaunch in the same cycle it sees done
                    if (go) begin
                        r_a     <= a_in;
                        r_b     <= b_in;
                        r_s     <= '0;
                        r_state <= E_RUN;
                    end else begin
                        r_state <= E_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy   = (r_state == E_RUN);
    assign done   = r_done;
    assign result = r_result;

endmodule

`default_nettype wire

// File: rtl/relprime_checker.sv
// ============================================================================
// Module   : relprime_checker
// Purpose  : Computes gcd(n,m), reports whether m is coprime to n and whether
//            m is the smallest coprime value >= 2, by sweeping k = 2..m-1
//            through a single shared GCD engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module relprime_checker
    import relprime_pkg::*;
#(
    parameter int WIDTH = c_WIDTH
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] register_value,
    input  logic [WIDTH-1:0] candidate,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] gcd_out,
    output logic             coprime,
    output logic             minimal,
    output logic             err
);

    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_TWO = WIDTH'(2);

    chk_state_t        r_state;
    logic [WIDTH-1:0]  r_n;
    logic [WIDTH-1:0]  r_m;
    logic [WIDTH-1:0]  r_k;
    logic              r_eng_go;
    logic              r_busy;
    logic              r_done;
    logic [WIDTH-1:0]  r_gcd;
    logic              r_coprime;
    logic              r_minimal;
    logic              r_err;

    logic              w_eng_busy;
    logic              w_eng_done;
    logic [WIDTH-1:0]  w_eng_result;
    logic [WIDTH-1:0]  w_eng_b;
    logic [WIDTH-1:0]  w_k_next;
    logic              w_eng_ready;

    // First launch is gcd(n,m); every sweep launch is gcd(n,k)
    assign w_eng_b     = (r_state == SWEEP) ? r_k : r_m;
    assign w_k_next    = r_k + c_ONE;
    assign w_eng_ready = w_eng_done && !w_eng_busy;

    gcd_engine #(
        .WIDTH (WIDTH)
    ) u_engine (
        .CLK    (CLK),
        .reset  (reset),
        .go     (r_eng_go),
        .a_in   (r_n),
        .b_in   (w_eng_b),
        .busy   (w_eng_busy),
        .done   (w_eng_done),
        .result (w_eng_result)
    );

    // Checker sequencing and registered result outputs
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state   <= IDLE;
            r_n       <= '0;
            r_m       <= '0;
            r_k       <= '0;
            r_eng_go  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_gcd     <= '0;
            r_coprime <= 1'b0;
            r_minimal <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_eng_go <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_n       <= register_value;
                        r_m       <= candidate;
                        r_gcd     <= '0;
                        r_coprime <= 1'b0;
                        r_minimal <= 1'b0;
                        r_err     <= 1'b0;
                        r_busy    <= 1'b1;
                        if (candidate < c_TWO) begin
                            r_err   <= 1'b1;
                            r_state <= FINISH;
                        end else begin
                            r_eng_go <= 1'b1;
                            r_state  <= CHECK_M;
                        end
                    end
                end
                CHECK_M: begin
                    if (w_eng_ready) begin
                        r_gcd     <= w_eng_result;
                        r_coprime <= (w_eng_result == c_ONE);
                        if (w_eng_result != c_ONE) begin
                            r_minimal <= 1'b0;
                            r_state   <= FINISH;
                        end else begin
                            r_k <= c_TWO;
                            if (r_m == c_TWO) begin
                                r_minimal <= 1'b1;
                                r_state   <= FINISH;
                            end else begin
                                r_eng_go <= 1'b1;
                                r_state  <= SWEEP;
                            end
                        end
                    end
                end
                SWEEP: begin
                    if (w_eng_ready) begin
                        if (w_eng_result == c_ONE) begin
                            // A smaller coprime value exists
                            r_minimal <= 1'b0;
                            r_state   <= FINISH;
                        end else begin
                            r_k <= w_k_next;
                            if (w_k_next == r_m) begin
                                r_minimal <= 1'b1;
                                r_state   <= FINISH;
                            end else begin
                                r_eng_go <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    // FINISH: one cycle to raise done, one to drop done/busy
                    if (!r_done) begin
                        r_done <= 1'b1;
                    end else begin
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign gcd_out = r_gcd;
    assign coprime = r_coprime;
    assign minimal = r_minimal;
    assign err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_relprime_checker.sv
// ============================================================================
// Module   : tb_relprime_checker
// Purpose  : Self-checking bench for relprime_checker against a plain
//            arithmetic reference (Euclid gcd and a direct coprime search).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_relprime_checker;
    import relprime_pkg::*;

    localparam int W      = 16;
    localparam int BUDGET = 3000;

    logic          CLK = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  register_value;
    logic [W-1:0]  candidate;
    logic          busy;
    logic          done;
    logic [W-1:0]  gcd_out;
    logic          coprime;
    logic          minimal;
    logic          err;

    int n_cmp  = 0;
    int n_bad  = 0;
    int done_count = 0;
    logic prev_done = 1'b0;

    // Expected visible results
    logic          e_valid = 1'b0;
    logic [W-1:0]  e_gcd   = '0;
    logic          e_cop   = 1'b0;
    logic          e_min   = 1'b0;
    logic          e_err   = 1'b0;

    relprime_checker #(.WIDTH(W)) dut (
        .CLK            (CLK),
        .reset          (reset),
        .start          (start),
        .register_value (register_value),
        .candidate      (candidate),
        .busy           (busy),
        .done           (done),
        .gcd_out        (gcd_out),
        .coprime        (coprime),
        .minimal        (minimal),
        .err            (err)
    );

    always #5 CLK = ~CLK;

    function automatic int unsigned ref_gcd(input int unsigned a, input int unsigned b);
        int unsigned x = a;
        int unsigned y = b;
        int unsigned t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Expected outputs straight from the definitions
    task automatic ref_model(input int unsigned n, input int unsigned m);
        int unsigned g;
        if (m < 2) begin
            e_gcd = '0; e_cop = 1'b0; e_min = 1'b0; e_err = 1'b1;
        end else begin
            g     = ref_gcd(n, m);
            e_gcd = W'(g);
            e_cop = (g == 1);
            e_err = 1'b0;
            e_min = e_cop;
            if (e_cop) begin
                for (int unsigned k = 2; k < m; k++) begin
                    if (ref_gcd(n, k) == 1) begin
                        e_min = 1'b0;
                        break;
                    end
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare results whenever they are meaningful: the done cycle and idle
    always @(negedge CLK) begin
        if (!reset && e_valid && (done || !busy)) begin
            check("gcd_out", 32'(gcd_out), 32'(e_gcd));
            check("coprime", 32'(coprime), 32'(e_cop));
            check("minimal", 32'(minimal), 32'(e_min));
            check("err",     32'(err),     32'(e_err));
        end
        if (!reset && done && prev_done)
            check("done_one_cycle", 32'(1), 32'(0));
        if (done && !prev_done)
            done_count++;
        prev_done = done;
    end

    task automatic launch(input int unsigned n, input int unsigned m);
        @(negedge CLK);
        register_value = W'(n);
        candidate      = W'(m);
        start          = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        ref_model(n, m);
    endtask

    task automatic wait_done(input string name, output int lat);
        int d0 = done_count;
        lat = 0;
        while (done_count == d0 && lat < BUDGET) begin
            @(negedge CLK);
            #1;
            lat++;
        end
        if (done_count == d0)
            check({name, "_timeout"}, 32'(0), 32'(1));
    endtask

    task automatic run(input int unsigned n, input int unsigned m, output int lat);
        launch(n, m);
        wait_done("run", lat);
        @(negedge CLK);
        #1;
        check("busy_drop", 32'(busy), 32'(0));
    endtask

    int lat;
    int d0;
    int unsigned rn, rm;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; register_value = '0; candidate = '0;
        repeat (3) @(posedge CLK);
        #1;
        reset   = 1'b0;
        e_valid = 1'b1;
        @(negedge CLK);
        #1;
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));

        // Hand-computed anchors (13050 = 2*3^2*5^2*29)
        run(13050, 7, lat);
        check("lit_7_gcd", 32'(gcd_out), 32'(1));
        check("lit_7_min", 32'(minimal), 32'(1));
        run(13050, 11, lat);
        check("lit_11_min", 32'(minimal), 32'(0));
        check("lit_11_cop", 32'(coprime), 32'(1));
        check("lit_11_early", 32'(lat <= 7 * (2 * W + 4) + 4), 32'(1));
        run(13050, 6, lat);
        check("lit_6_gcd", 32'(gcd_out), 32'(6));
        run(0, 12, lat);
        check("lit_0_12_gcd", 32'(gcd_out), 32'(12));
        run(5, 2, lat);
        check("lit_5_2_min", 32'(minimal), 32'(1));
        run(13050, 1, lat);
        check("lit_err", 32'(err), 32'(1));
        check("err_latency", 32'(lat <= 3), 32'(1));
        run(7, 0, lat);

        // Start while busy and start in the done cycle are both ignored
        launch(13050, 7);
        repeat (3) @(negedge CLK);
        register_value = 16'd10; candidate = 16'd3; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        wait_done("ignore", lat);
        register_value = 16'd4; candidate = 16'd1; start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        d0 = done_count;
        @(negedge CLK);
        #1;
        check("done_cycle_start_busy", 32'(busy), 32'(0));
        repeat (10) @(negedge CLK);
        check("done_cycle_start_ignored", 32'(done_count), 32'(d0));

        // Reset mid-operation aborts with all outputs cleared
        launch(13050, 11);
        repeat (60) @(negedge CLK);
        check("busy_mid", 32'(busy), 32'(1));
        reset = 1'b1;
        @(posedge CLK);
        #1;
        reset = 1'b0;
        e_gcd = '0; e_cop = 1'b0; e_min = 1'b0; e_err = 1'b0;
        d0 = done_count;
        @(negedge CLK);
        #1;
        check("abort_busy", 32'(busy), 32'(0));
        repeat (400) @(negedge CLK);
        check("abort_no_done", 32'(done_count), 32'(d0));
        run(13050, 11, lat);

        // Randomized operands
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) rn = $urandom_range(0, 200);
            else                           rn = $urandom_range(0, 65535);
            if (rn != 0 && $urandom_range(0, 3) == 0) rm = $urandom_range(0, 65535);
            else                                      rm = $urandom_range(0, 64);
            run(rn, rm, lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
